// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder controller.
//   - state_e       : controller state encoding
//   - DEFAULT_WIDTH : default operand/result width
//   - cnt_width()   : bit counter width for a given operand width
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    // The lower bound of 1 keeps the vector legal for degenerate widths.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
//   sum  - a ^ b ^ cin
//   cout - carry out
//   a, b - operand bits
//   cin  - carry in
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder built around one full_adder.
// Operands are captured on an accepted start and fed LSB first, one bit
// pair per clock; the result is reported with a one-cycle done pulse.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - request pulse, accepted in IDLE or DONE
//   a, b  - operands, captured on accepted start
//   cin   - carry-in, captured on accepted start
//   busy  - computation in progress
//   done  - one-cycle pulse, sum/cout valid
//   sum   - result, held until the next done
//   cout  - final carry-out, held with sum
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one bit pair added per clock, WIDTH clocks total
// DONE  | result just published; start here chains the next operation
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign acc_d = {fa_sum, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= acc_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for done. Caller sits #1 after
    // a rising edge. Returns edges from the start edge to done (0 on timeout)
    // and the number of cycles busy was seen high.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          output int lat, output int bcnt,
                          output logic [W-1:0] s, output logic c);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        s = sum; c = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        total++; if ({busy, done, sum, cout} !== 11'd0) begin bad++; $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat, bc; logic [W-1:0] s; logic c;
        run_op(8'h00, 8'h00, 1'b0, lat, bc, s, c);
        total++; if (lat !== 8) begin bad++; $display("FAIL zero_latency got %0d want 8", lat); end
        total++; if (bc !== 8) begin bad++; $display("FAIL zero_busy_cycles got %0d want 8", bc); end
        total++; if ({c, s} !== 9'h000) begin bad++; $display("FAIL zero_result got %b_%h want 0_00", c, s); end
        @(posedge clk); #1;
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_done_width got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_add();
        int lat, bc; logic [W-1:0] s; logic c;
        run_op(8'hFF, 8'h01, 1'b0, lat, bc, s, c);
        total++; if ({c, s} !== 9'h100 || lat !== 8) begin bad++; $display("FAIL add_ff_01 got %b_%h lat=%0d want 1_00 lat=8", c, s, lat); end
        @(posedge clk); #1;
        run_op(8'h3C, 8'h0F, 1'b0, lat, bc, s, c);
        total++; if ({c, s} !== 9'h04B || lat !== 8) begin bad++; $display("FAIL add_3c_0f got %b_%h lat=%0d want 0_4b lat=8", c, s, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_capture();
        int lat = 0;
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin a = 8'h00; b = 8'hFF; cin = 1'b0; end
            @(posedge clk); #1;
            total++; if (k < 8 && sum !== 8'h4B) begin bad++; $display("FAIL capture_sum_hold k=%0d got %h want 4b", k, sum); end
            if (done) begin lat = k; break; end
        end
        total++; if ({cout, sum} !== 9'h100 || lat !== 8) begin bad++; $display("FAIL capture_result got %b_%h lat=%0d want 1_00 lat=8", cout, sum, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int first = 0;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin start = 1'b1; a = 8'h11; b = 8'h22; end
            if (k == 4) start = 1'b0;
            @(posedge clk); #1;
            if (done) begin ndone++; if (first == 0) first = k; end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        total++; if (first !== 8) begin bad++; $display("FAIL ignore_latency got %0d want 8", first); end
        total++; if ({cout, sum} !== 9'h003) begin bad++; $display("FAIL ignore_result got %b_%h want 0_03", cout, sum); end
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic [W-1:0] s; logic c;
        int lat2 = 0;
        run_op(8'h3C, 8'h0F, 1'b0, lat, bc, s, c);
        total++; if ({c, s} !== 9'h04B) begin bad++; $display("FAIL b2b_first got %b_%h want 0_4b", c, s); end
        a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept got busy=%b done=%b want 1 0", busy, done); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin lat2 = k; break; end
            total++; if ({cout, sum} !== 9'h04B) begin bad++; $display("FAIL b2b_hold k=%0d got %b_%h want 0_4b", k, cout, sum); end
        end
        total++; if (lat2 !== 8) begin bad++; $display("FAIL b2b_latency got %0d want 8", lat2); end
        total++; if ({cout, sum} !== 9'h101) begin bad++; $display("FAIL b2b_second got %b_%h want 1_01", cout, sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int lat, bc; logic [W-1:0] s; logic c;
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({busy, done, sum, cout} !== 11'd0) begin bad++; $display("FAIL rstmid_async got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done got %0d active cycles want 0", ndone); end
        run_op(8'h12, 8'h34, 1'b0, lat, bc, s, c);
        total++; if ({c, s} !== 9'h046 || lat !== 8) begin bad++; $display("FAIL rstmid_after got %b_%h lat=%0d want 0_46 lat=8", c, s, lat); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_add();
        test_capture();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
